julia_frame_ctrl: RTL
=====================

Name: julia_frame_ctrl

Overview:
- Frame-level initiator for the Julia iteration engine. Sweeps every pixel of an H_RES x V_RES frame in raster order.
- For each pixel: drives the pixel's fixed-point start point (ZR/ZI) and the frame constant (CR/CI), pulses CALC_START, waits for CALC_END, then writes the saturated iteration count to the framebuffer.
- Sits between the top-level frame trigger and the engine/framebuffer write port.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- ADDR_W, 19, framebuffer address width.
- X_START, -(3*8192)/2, real part of pixel (0,0), Q18.13 (scale 8192).
- Y_START, (1*8192), imaginary part of pixel (0,0), Q18.13.
- STEP_X, 8192*3/640, real increment per pixel, Q18.13.
- STEP_Y, 8192*2/480, imaginary decrement per line, Q18.13.
- TIMEOUT, 4096, maximum cycles to wait for CALC_END per pixel.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- FRAME_GO  in  1  start one frame; sampled only in IDLE.
- CR_IN  in  32 signed  frame constant, real part; latched on accepted FRAME_GO.
- CI_IN  in  32 signed  frame constant, imaginary part; latched on accepted FRAME_GO.
- ZR  out  32 signed  pixel real coordinate to engine.
- ZI  out  32 signed  pixel imaginary coordinate to engine.
- CR  out  32 signed  latched frame constant, real part.
- CI  out  32 signed  latched frame constant, imaginary part.
- CALC_START  out  1  one-cycle start pulse to engine.
- CALC_NUM  in  32 signed  iteration count from engine.
- CALC_END  in  1  engine done level.
- WR_VALID  out  1  framebuffer write request.
- WR_READY  in  1  framebuffer accepts write.
- WR_ADDR  out  ADDR_W  pixel address, y*H_RES+x.
- WR_DATA  out  8  saturated iteration count.
- BUSY  out  1  high in any state other than IDLE.
- FRAME_DONE  out  1  one-cycle pulse after the last pixel write is accepted.
- TMO_ERR  out  1  sticky: set if any pixel timed out; cleared on accepted FRAME_GO or RST.

Behaviour:
- Reset: synchronous, highest priority, honoured in every state. Outputs and state on RST:
  - State = IDLE.
  - All outputs 0, including ZR/ZI/CR/CI, WR_ADDR, WR_DATA, TMO_ERR.
  - x, y and address counters = 0.
- Fixed-point format: Q18.13 two's complement. Coordinates are formed incrementally; no multiplier.
  - ZR = X_START + x*STEP_X, via an accumulator that reloads X_START at line start.
  - ZI = Y_START - y*STEP_Y.
  - Wrap-around of 32-bit sums is not checked.
- States:
  - IDLE: when FRAME_GO=1, latch CR_IN/CI_IN into CR/CI, clear TMO_ERR, set x=y=addr=0, ZR=X_START, ZI=Y_START, go to ARM. FRAME_GO in any other state is ignored.
  - ARM: CALC_START=1 for exactly this one cycle. ZR/ZI/CR/CI are already stable and are held unchanged until the pixel's write is accepted. Clear the watchdog; go to DROP.
  - DROP: wait for CALC_END=0, which the engine clears on the start edge. Then go to WAIT.
  - WAIT: when CALC_END=1, capture CALC_NUM and go to WRITE.
    - Captured value: WR_DATA = 255 if CALC_NUM>255; 0 if CALC_NUM<0; else CALC_NUM[7:0].
  - Watchdog: counts in DROP and WAIT. When it reaches TIMEOUT, set WR_DATA=255, set TMO_ERR, go to WRITE.
  - WRITE: WR_VALID=1 with WR_ADDR/WR_DATA held stable until the cycle WR_READY=1. On that cycle, drop WR_VALID and advance:
    - If x<H_RES-1: x+1, ZR+=STEP_X.
    - Else x=0, ZR=X_START; and if y<V_RES-1: y+1, ZI-=STEP_Y.
    - Else (last pixel): go to DONE.
    - addr increments by 1 on every accepted write.
    - Otherwise go to ARM.
  - DONE: FRAME_DONE=1 for one cycle, then IDLE. A FRAME_GO arriving in DONE is ignored.
- Timing:
  - Minimum per-pixel cost is 4 cycles (ARM, DROP, WAIT, WRITE) plus engine latency.
  - CALC_START is never high on two consecutive cycles, and is low for at least 3 cycles between pulses.
- Boundary conditions:
  - CALC_END already 0 in DROP: DROP lasts 1 cycle.
  - WR_READY held 0: WRITE stalls indefinitely; the watchdog does not run in WRITE.
  - RST during WAIT: CALC_START stays 0 and the engine result is discarded.
  - H_RES=1 or V_RES=1 must work.

Test Plan:
- Reset mid-frame: H_RES=4, V_RES=3; assert RST while in WAIT of pixel 5 -> next cycle BUSY=0, WR_VALID=0, CALC_START=0, WR_ADDR=0; a following FRAME_GO restarts at address 0.
- Full frame with engine model (CALC_END 10 cycles after start, CALC_NUM=addr*30), WR_READY=1: H_RES=4, V_RES=3 ->
  - 12 writes at addresses 0..11.
  - WR_DATA = 0,30,...,240,255,255,255 (saturation from addr 9).
  - Exactly one FRAME_DONE, after the write to address 11.
- Coordinates: X_START=-12288, STEP_X=100, Y_START=8192, STEP_Y=50, H_RES=4 -> at pixel (3,1): ZR=-11988, ZI=8142; at pixel (0,2): ZR=-12288, ZI=8092.
- Timeout: TIMEOUT=16; engine never raises CALC_END for pixel 2 -> pixel 2 written with 255 about 16 cycles after its DROP; TMO_ERR=1 until the next accepted FRAME_GO.
- Backpressure: WR_READY low for 7 cycles on pixel 0 -> WR_VALID/WR_ADDR/WR_DATA and ZR/ZI stable throughout; no second CALC_START before acceptance.
- Frame constant and start protocol: CR_IN=-3277, CI_IN=1638 at FRAME_GO, then CR_IN changed mid-frame -> CR/CI outputs stay -3277/1638 for the whole frame; FRAME_GO while BUSY has no effect.

Source files
------------

// File: rtl/julia_frame_ctrl.sv
// Frame-level initiator for the Julia engine: walks the frame in raster order,
// starts one engine run per pixel and writes the saturated count to the framebuffer.
module julia_frame_ctrl #(
    parameter int               H_RES   = 640,
    parameter int               V_RES   = 480,
    parameter int               ADDR_W  = 19,
    parameter logic signed [31:0] X_START = -(3*8192)/2,
    parameter logic signed [31:0] Y_START = (1*8192),
    parameter logic signed [31:0] STEP_X  = 8192*3/640,
    parameter logic signed [31:0] STEP_Y  = 8192*2/480,
    parameter int               TIMEOUT = 4096
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                FRAME_GO,
    input  logic signed [31:0]  CR_IN,
    input  logic signed [31:0]  CI_IN,
    output logic signed [31:0]  ZR,
    output logic signed [31:0]  ZI,
    output logic signed [31:0]  CR,
    output logic signed [31:0]  CI,
    output logic                CALC_START,
    input  logic signed [31:0]  CALC_NUM,
    input  logic                CALC_END,
    output logic                WR_VALID,
    input  logic                WR_READY,
    output logic [ADDR_W-1:0]   WR_ADDR,
    output logic [7:0]          WR_DATA,
    output logic                BUSY,
    output logic                FRAME_DONE,
    output logic                TMO_ERR
);
    localparam int XW   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW   = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_DROP, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic signed [31:0]  zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
    logic [7:0]          data_q, data_d;
    logic                tmo_q, tmo_d;
    logic                start_q, start_d, valid_q, valid_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                wd_expired;

    assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        data_d  = data_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (FRAME_GO) begin
                    cr_d    = CR_IN;
                    ci_d    = CI_IN;
                    tmo_d   = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    zr_d    = X_START;
                    zi_d    = Y_START;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                wd_d    = '0;
                state_d = S_DROP;
            end
            S_DROP: begin
                wd_d = wd_q + 1'b1;
                if (wd_expired) begin
                    data_d  = 8'hFF;
                    tmo_d   = 1'b1;
                    state_d = S_WRITE;
                end else if (!CALC_END) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                // A result arriving on the last watchdog cycle still wins.
                if (CALC_END) begin
                    if (CALC_NUM > 32'sd255)
                        data_d = 8'hFF;
                    else if (CALC_NUM < 32'sd0)
                        data_d = 8'h00;
                    else
                        data_d = CALC_NUM[7:0];
                    state_d = S_WRITE;
                end else if (wd_expired) begin
                    data_d  = 8'hFF;
                    tmo_d   = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (WR_READY) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_ARM;
                    if (x_q != XW'(H_RES - 1)) begin
                        x_d  = x_q + 1'b1;
                        zr_d = zr_q + STEP_X;
                    end else begin
                        x_d  = '0;
                        zr_d = X_START;
                        if (y_q != YW'(V_RES - 1)) begin
                            y_d  = y_q + 1'b1;
                            zi_d = zi_q - STEP_Y;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they register in step with it.
        start_d = (state_d == S_ARM);
        valid_d = (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            cr_q    <= '0;
            ci_q    <= '0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            start_q <= start_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ZR         = zr_q;
    assign ZI         = zi_q;
    assign CR         = cr_q;
    assign CI         = ci_q;
    assign CALC_START = start_q;
    assign WR_VALID   = valid_q;
    assign WR_ADDR    = addr_q;
    assign WR_DATA    = data_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign TMO_ERR    = tmo_q;
endmodule
